// File: rtl/l2_arbiter.sv
// Two-port arbiter sharing the L2 CPU-side request port between the L1 I-cache and L1 D-cache.
// Define L2_ARB_RR_EN for round-robin arbitration; otherwise the D-cache wins on contention.
module l2_arbiter #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_cyc,
   input  logic              i_stb,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [LINE_W-1:0] i_rdata,
   input  logic              d_cyc,
   input  logic              d_stb,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [LINE_W-1:0] d_rdata,
   output logic              l2_cyc,
   output logic              l2_stb,
   output logic              l2_we,
   output logic [ADDR_W-1:0] l2_addr,
   output logic [LINE_W-1:0] l2_wdata,
   input  logic              l2_ack,
   input  logic [LINE_W-1:0] l2_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT_I = 2'd1,
      GRANT_D = 2'd2
   } state_t;

   state_t state_q, state_d;
   logic   i_pend, d_pend;

   assign i_pend = i_cyc & i_stb;
   assign d_pend = d_cyc & d_stb;

`ifdef L2_ARB_RR_EN
   // High when the most recently completed grant went to the D-cache.
   logic last_d_q, last_d_d;
`endif

   always_comb begin
      state_d = state_q;
`ifdef L2_ARB_RR_EN
      last_d_d = last_d_q;
`endif
      case (state_q)
         IDLE: begin
            if (i_pend && d_pend) begin
`ifdef L2_ARB_RR_EN
               state_d = last_d_q ? GRANT_I : GRANT_D;
`else
               state_d = GRANT_D;
`endif
            end else if (d_pend) begin
               state_d = GRANT_D;
            end else if (i_pend) begin
               state_d = GRANT_I;
            end
         end
         GRANT_I: begin
            if (l2_ack) begin
               state_d = IDLE;
`ifdef L2_ARB_RR_EN
               last_d_d = 1'b0;
`endif
            end else if (!i_cyc) begin
               // Aborted access: release without touching the fairness history.
               state_d = IDLE;
            end
         end
         GRANT_D: begin
            if (l2_ack) begin
               state_d = IDLE;
`ifdef L2_ARB_RR_EN
               last_d_d = 1'b1;
`endif
            end else if (!d_cyc) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
`ifdef L2_ARB_RR_EN
         last_d_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
`ifdef L2_ARB_RR_EN
         last_d_q <= last_d_d;
`endif
      end
   end

   // Steering follows the registered state, so reset drops l2_cyc without a clock edge.
   always_comb begin
      l2_cyc   = 1'b0;
      l2_stb   = 1'b0;
      l2_we    = 1'b0;
      l2_addr  = '0;
      l2_wdata = '0;
      i_ack    = 1'b0;
      d_ack    = 1'b0;
      case (state_q)
         GRANT_I: begin
            l2_cyc  = i_cyc;
            l2_stb  = i_stb;
            l2_addr = i_addr;
            i_ack   = l2_ack;
         end
         GRANT_D: begin
            l2_cyc   = d_cyc;
            l2_stb   = d_stb;
            l2_we    = d_we;
            l2_addr  = d_addr;
            l2_wdata = d_wdata;
            d_ack    = l2_ack;
         end
         default: ;
      endcase
   end

   assign i_rdata = l2_rdata;
   assign d_rdata = l2_rdata;
   assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected transactions are queued when requests are
// driven and matched against each forwarded acknowledge.
module tb_l2_arbiter;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;

   logic              clk;
   logic              rst_n;
   logic              i_cyc, i_stb;
   logic [ADDR_W-1:0] i_addr;
   logic              i_ack;
   logic [LINE_W-1:0] i_rdata;
   logic              d_cyc, d_stb, d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic              d_ack;
   logic [LINE_W-1:0] d_rdata;
   logic              l2_cyc, l2_stb, l2_we;
   logic [ADDR_W-1:0] l2_addr;
   logic [LINE_W-1:0] l2_wdata;
   logic              l2_ack;
   logic [LINE_W-1:0] l2_rdata;
   logic              busy;

   l2_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk(clk), .rst_n(rst_n),
      .i_cyc(i_cyc), .i_stb(i_stb), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_cyc(d_cyc), .d_stb(d_stb), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .l2_cyc(l2_cyc), .l2_stb(l2_stb), .l2_we(l2_we), .l2_addr(l2_addr),
      .l2_wdata(l2_wdata), .l2_ack(l2_ack), .l2_rdata(l2_rdata), .busy(busy)
   );

   typedef struct {
      bit                is_d;
      bit                we;
      logic [ADDR_W-1:0] addr;
      logic [LINE_W-1:0] wdata;
      logic [LINE_W-1:0] rdata;
   } sb_t;

   sb_t sb_q[$];
   sb_t mon_e;
   int  n_tests = 0;
   int  n_fail  = 0;

   localparam logic [LINE_W-1:0] PAT_A5 = {32{8'hA5}};
   localparam logic [LINE_W-1:0] PAT_55 = {32{8'h55}};
   localparam logic [LINE_W-1:0] PAT_DB = {8{32'hDEADBEEF}};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [LINE_W-1:0] got,
                        input logic [LINE_W-1:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every forwarded ack must match the oldest outstanding expected transaction.
   always @(negedge clk) begin
      if (i_ack || d_ack) begin
         if (sb_q.size() == 0) begin
            check("sb_unexpected_ack", 1, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check("sb_both_ack", i_ack & d_ack, 0);
            check("sb_port", d_ack, mon_e.is_d);
            check("sb_addr", l2_addr, mon_e.addr);
            check("sb_we", l2_we, mon_e.we);
            check("sb_wdata", l2_wdata, mon_e.wdata);
            check("sb_rdata", d_ack ? d_rdata : i_rdata, mon_e.rdata);
         end
      end
   end

   task automatic push_exp(input bit is_d, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd);
      sb_t e;
      e.is_d  = is_d;
      e.we    = we;
      e.addr  = addr;
      e.wdata = is_d ? wd : '0;
      e.rdata = rd;
      sb_q.push_back(e);
   endtask

   // Starts just after a rising edge with the arbiter idle; grant is expected one cycle later.
   task automatic txn(input bit is_d, input bit we, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] wd, input logic [LINE_W-1:0] rd,
                      input int wait_cyc);
      push_exp(is_d, we, addr, wd, rd);
      if (is_d) begin
         d_cyc = 1'b1; d_stb = 1'b1; d_we = we; d_addr = addr; d_wdata = wd;
      end else begin
         i_cyc = 1'b1; i_stb = 1'b1; i_addr = addr;
      end
      tick();
      for (int k = 0; k <= wait_cyc; k++) begin
         if (k == wait_cyc) begin
            l2_ack   = 1'b1;
            l2_rdata = rd;
         end
         @(negedge clk);
         check("txn_cyc", l2_cyc, 1);
         check("txn_stb", l2_stb, 1);
         check("txn_addr", l2_addr, addr);
         check("txn_we", l2_we, we);
         check("txn_wdata", l2_wdata, is_d ? wd : '0);
         check("txn_busy", busy, 1);
         check("txn_other_ack", is_d ? i_ack : d_ack, 0);
         tick();
      end
      l2_ack = 1'b0;
      i_cyc = 1'b0; i_stb = 1'b0;
      d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
      @(negedge clk);
      check("txn_idle_after", busy, 0);
      check("txn_idle_cyc", l2_cyc, 0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit exp_d;
      rst_n = 1'b0;
      i_cyc = 1'b0; i_stb = 1'b0; i_addr = '0;
      d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      l2_ack = 1'b0; l2_rdata = '0;

      #3;
      check("rst_l2_cyc", l2_cyc, 0);
      check("rst_l2_stb", l2_stb, 0);
      check("rst_l2_we", l2_we, 0);
      check("rst_l2_addr", l2_addr, 0);
      check("rst_l2_wdata", l2_wdata, 0);
      check("rst_i_ack", i_ack, 0);
      check("rst_d_ack", d_ack, 0);
      check("rst_busy", busy, 0);
      tick();
      tick();
      rst_n = 1'b1;

      // Continuous contention straight after reset, so the fairness history starts at I.
      i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h3000;
      d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b0; d_addr = 32'h4000; d_wdata = PAT_DB;
      for (int k = 0; k < 4; k++) begin
`ifdef L2_ARB_RR_EN
         exp_d = (k % 2 == 0);
`else
         exp_d = 1'b1;
`endif
         push_exp(exp_d, 1'b0, exp_d ? 32'h4000 : 32'h3000, PAT_DB, PAT_A5 + LINE_W'(k));
      end
      for (int k = 0; k < 4; k++) begin
         tick();
         l2_ack   = 1'b1;
         l2_rdata = PAT_A5 + LINE_W'(k);
         @(negedge clk);
         check("cont_busy", busy, 1);
         tick();
         l2_ack = 1'b0;
         if (k == 3) begin
            i_cyc = 1'b0; i_stb = 1'b0;
            d_cyc = 1'b0; d_stb = 1'b0;
         end
         @(negedge clk);
         check("cont_gap_idle", busy, 0);
      end
      tick();

      txn(1'b0, 1'b0, 32'h1000, '0, PAT_A5, 2);
      txn(1'b1, 1'b1, 32'h2040, PAT_55, '0, 0);

      // Abort: I granted, then withdraws before any ack.
      i_cyc = 1'b1; i_stb = 1'b1; i_addr = 32'h5000;
      tick();
      @(negedge clk);
      check("abort_granted", busy, 1);
      check("abort_cyc_on", l2_cyc, 1);
      tick();
      i_cyc = 1'b0; i_stb = 1'b0;
      tick();
      @(negedge clk);
      check("abort_l2_cyc", l2_cyc, 0);
      check("abort_busy", busy, 0);
      check("abort_i_ack", i_ack, 0);
      tick();
      txn(1'b1, 1'b0, 32'h2080, PAT_DB, PAT_55, 1);

      // Spurious ack while idle must not be forwarded or change state.
      l2_ack = 1'b1; l2_rdata = PAT_A5;
      @(negedge clk);
      check("spur_i_ack", i_ack, 0);
      check("spur_d_ack", d_ack, 0);
      check("spur_busy", busy, 0);
      tick();
      @(negedge clk);
      check("spur_busy2", busy, 0);
      tick();
      l2_ack = 1'b0;

      // Reset asserted between clock edges while D holds the grant.
      d_cyc = 1'b1; d_stb = 1'b1; d_we = 1'b1; d_addr = 32'h6000; d_wdata = PAT_55;
      tick();
      @(negedge clk);
      check("rstmid_pre_busy", busy, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rstmid_l2_cyc", l2_cyc, 0);
      check("rstmid_busy", busy, 0);
      check("rstmid_l2_we", l2_we, 0);
      d_cyc = 1'b0; d_stb = 1'b0; d_we = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      txn(1'b0, 1'b0, 32'h7000, '0, PAT_55, 0);

      check("sb_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
